// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : piso_shift_reg
//  Purpose  : Parallel-in, serial-out shift register. Captures a WIDTH-bit
//             word on a load strobe and shifts it out one bit per enabled
//             clock, then pulses done for one cycle. Bit order matches a
//             receiving shift_reg that shifts incoming bits toward its MSB.
//  Options  : PISO_PARITY_EN - when defined, an even-parity bit (XOR of din)
//             is captured on load and sent after the last data bit, making
//             the frame WIDTH+1 bits long.
//  Ports    : clk   - clock, rising edge
//             rstn  - asynchronous active-low reset
//             din   - parallel word, sampled on an accepted load
//             load  - load strobe, accepted only while idle
//             en    - shift enable, serial bit advances when high
//             dout  - registered serial data
//             busy  - high while a frame is being shifted out
//             done  - one-cycle pulse after the final bit is consumed
//  Revision : 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
    parameter int WIDTH     = 5,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             en,
    output logic             dout,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int C_FRAME_BITS = WIDTH + 1;
`else
    localparam int C_FRAME_BITS = WIDTH;
`endif
    localparam int C_CNT_W = $clog2(C_FRAME_BITS + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_n;
    logic [C_FRAME_BITS-1:0] r_sr;
    logic [C_FRAME_BITS-1:0] w_sr_n;
    logic [C_FRAME_BITS-1:0] w_load_word;
    logic [C_CNT_W-1:0]      r_cnt;
    logic [C_CNT_W-1:0]      w_cnt_n;
    logic                    r_dout;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_dout_n;
    logic                    w_busy_n;
    logic                    w_done_n;

    // The parity bit sits at the tail of the register so that it reaches
    // the head only after every data bit has been shifted out.
`ifdef PISO_PARITY_EN
    assign w_load_word = (MSB_FIRST != 0) ? {din, ^din} : {^din, din};
`else
    assign w_load_word = din;
`endif

    always_comb begin
        w_state_n = r_state;
        w_sr_n    = r_sr;
        w_cnt_n   = r_cnt;
        w_done_n  = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_sr_n    = w_load_word;
                    w_cnt_n   = C_CNT_W'(C_FRAME_BITS);
                    w_state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    // Shift toward the head, zero-filling the vacated bit.
                    w_sr_n  = (MSB_FIRST != 0) ? (r_sr << 1) : (r_sr >> 1);
                    w_cnt_n = r_cnt - C_CNT_W'(1);
                    if (r_cnt == C_CNT_W'(1)) begin
                        w_state_n = IDLE;
                        w_done_n  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
        // Outputs are registered from next-state values so the head bit is
        // on dout in the same cycle the state says SHIFT, with no path from
        // inputs straight to outputs.
        w_busy_n = (w_state_n == SHIFT);
        w_dout_n = w_busy_n &
                   ((MSB_FIRST != 0) ? w_sr_n[C_FRAME_BITS-1] : w_sr_n[0]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sr    <= w_sr_n;
            r_cnt   <= w_cnt_n;
            r_dout  <= w_dout_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign dout = r_dout;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
